// File: rtl/ddr_arb_pkg.sv
// ----------------------------------------------------------------------------
// ddr_arb_pkg
// Shared types and default widths for the DDR4 Avalon-MM burst arbiter.
//   t_arb_state : arbiter FSM states
//   t_arb_id    : master identifier (0 = DMA, 1 = host/MMIO)
//   t_rd_track  : one outstanding read command {originating master, burst length}
//   sat_inc32   : saturating 32-bit increment used by the optional counters
// ----------------------------------------------------------------------------
package ddr_arb_pkg;

    localparam int ARB_DATA_W         = 512;
    localparam int ARB_ADDR_W         = 27;
    localparam int ARB_BURST_W        = 7;
    localparam int ARB_RD_TRACK_DEPTH = 16;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_CMD    = 2'd1,
        ARB_WBURST = 2'd2
    } t_arb_state;

    typedef logic t_arb_id;

    // The beat field is sized by the package width; the top-level BURST_W
    // parameter is expected to keep this default.
    typedef struct packed {
        t_arb_id                id;
        logic [ARB_BURST_W-1:0] beats;
    } t_rd_track;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/ddr_avmm_burst_arbiter_rd_track_fifo.sv
// ----------------------------------------------------------------------------
// rd_track_fifo
// Synchronous show-ahead FIFO of outstanding read commands. Storage is a plain
// array with a registered read port; the head register is pre-fetched from the
// slot that will be at the head after this cycle's pop.
//   clk, reset  : clock, synchronous active-high reset
//   push        : write push_data (ignored while full, even if popping)
//   push_data   : entry to store
//   pop         : discard the head entry (ignored while empty)
//   full, empty : occupancy flags
//   head        : oldest entry, valid whenever empty is low
// ----------------------------------------------------------------------------
module rd_track_fifo
    import ddr_arb_pkg::*;
#(
    parameter int DEPTH = ARB_RD_TRACK_DEPTH
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  t_rd_track push_data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output t_rd_track head
);

    localparam int PTR_W = $clog2(DEPTH);

    t_rd_track        mem [DEPTH];
    t_rd_track        head_reg;
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic [PTR_W:0]   rd_ptr_next;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign rd_ptr_next = do_pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    assign head        = head_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_ptr_next;
            // A slot being written while it is also the next head would be
            // read stale from the array, so forward the incoming entry.
            if (do_push && (wr_ptr_reg[PTR_W-1:0] == rd_ptr_next[PTR_W-1:0])) begin
                head_reg <= push_data;
            end else begin
                head_reg <= mem[rd_ptr_next[PTR_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/ddr_avmm_burst_arbiter.sv
// ----------------------------------------------------------------------------
// ddr_avmm_burst_arbiter
// Shares one DDR4 Avalon-MM slave between DMA master 0 and host master 1.
// Round-robin between commands, write bursts hold the grant until their last
// beat, and outstanding read bursts are tracked so returned beats are flagged
// to the master that issued them (readdata itself is broadcast).
//   clk, reset                    : DDR4 user clock, synchronous active-high reset
//   m0_* / m1_*                   : Avalon-MM master ports
//   s_*                           : Avalon-MM port towards the DDR4 controller
// Optional build macro DDR_ARB_PERF_CNT_EN adds saturating counters:
//   perf_m0_cmds, perf_m1_cmds    : accepted reads + completed write bursts
//   perf_stall_cycles             : cycles with a requesting master stalled
// ----------------------------------------------------------------------------
module ddr_avmm_burst_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int DATA_W         = ARB_DATA_W,
    parameter int ADDR_W         = ARB_ADDR_W,
    parameter int BURST_W        = ARB_BURST_W,
    parameter int RD_TRACK_DEPTH = ARB_RD_TRACK_DEPTH
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [BURST_W-1:0]  m0_burstcount,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [BURST_W-1:0]  m1_burstcount,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic                s_read,
    output logic                s_write,
    output logic [ADDR_W-1:0]   s_address,
    output logic [BURST_W-1:0]  s_burstcount,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid
`ifdef DDR_ARB_PERF_CNT_EN
    ,
    output logic [31:0]         perf_m0_cmds,
    output logic [31:0]         perf_m1_cmds,
    output logic [31:0]         perf_stall_cycles
`endif
);

    t_arb_state           state_reg;
    t_arb_id              grant_id_reg;
    t_arb_id              rr_prio_reg;
    logic [BURST_W-1:0]   wr_beats_reg;
    logic [BURST_W-1:0]   burst_reg;
    logic [BURST_W-1:0]   rd_beats_reg;
    logic [BURST_W-1:0]   rd_beats_next;
    logic [BURST_W-1:0]   rd_cur;

    logic                 gm_read;
    logic                 gm_write;
    logic [BURST_W-1:0]   gm_burstcount;
    logic                 gm_wait;
    logic [1:0]           m_wait;
    logic [1:0]           m_rdv;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    t_rd_track            fifo_head;
    t_rd_track            fifo_push_data;

    logic                 wr_accept;
    logic                 wr_last;
    logic                 rdv_fire;

    // ---------------- granted-master selection ----------------
    assign gm_read       = grant_id_reg ? m1_read       : m0_read;
    assign gm_write      = grant_id_reg ? m1_write      : m0_write;
    assign gm_burstcount = grant_id_reg ? m1_burstcount : m0_burstcount;

    assign s_address     = grant_id_reg ? m1_address    : m0_address;
    assign s_writedata   = grant_id_reg ? m1_writedata  : m0_writedata;
    assign s_byteenable  = grant_id_reg ? m1_byteenable : m0_byteenable;
    // Later beats of a burst repeat the length latched with the first beat.
    assign s_burstcount  = (state_reg == ARB_WBURST) ? burst_reg : gm_burstcount;

    // Strobes are gated by state; a read is only offered while a tracking slot
    // is free, and reads are never offered in the middle of a write burst.
    always_comb begin
        s_read  = 1'b0;
        s_write = 1'b0;
        gm_wait = 1'b1;
        case (state_reg)
            ARB_CMD: begin
                if (gm_write) begin
                    s_write = 1'b1;
                    gm_wait = s_waitrequest;
                end else if (gm_read && !fifo_full) begin
                    s_read  = 1'b1;
                    gm_wait = s_waitrequest;
                end
            end
            ARB_WBURST: begin
                if (gm_write) begin
                    s_write = 1'b1;
                    gm_wait = s_waitrequest;
                end
            end
            default: ;
        endcase
    end

    assign wr_accept = s_write && !s_waitrequest;
    assign wr_last   = ((state_reg == ARB_CMD)    && (gm_burstcount == BURST_W'(1))) ||
                       ((state_reg == ARB_WBURST) && (wr_beats_reg  == BURST_W'(1)));
    assign fifo_push = (state_reg == ARB_CMD) && s_read && !s_waitrequest;
    assign fifo_push_data = '{id: grant_id_reg, beats: ARB_BURST_W'(gm_burstcount)};

    // ---------------- per-master outputs ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            assign m_wait[gi] = ((state_reg != ARB_IDLE) && (grant_id_reg == t_arb_id'(gi)))
                                ? gm_wait : 1'b1;
            assign m_rdv[gi]  = rdv_fire && (fifo_head.id == t_arb_id'(gi));
        end
    endgenerate

    assign m0_waitrequest   = m_wait[0];
    assign m1_waitrequest   = m_wait[1];
    assign m0_readdatavalid = m_rdv[0];
    assign m1_readdatavalid = m_rdv[1];
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

    // ---------------- arbiter FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ARB_IDLE;
            grant_id_reg <= 1'b0;
            rr_prio_reg  <= 1'b0;
            wr_beats_reg <= '0;
            burst_reg    <= '0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (m0_read || m0_write || m1_read || m1_write) begin
                        if ((m0_read || m0_write) && (m1_read || m1_write)) begin
                            grant_id_reg <= rr_prio_reg;
                        end else begin
                            grant_id_reg <= (m1_read || m1_write);
                        end
                        state_reg <= ARB_CMD;
                    end
                end
                ARB_CMD: begin
                    if (wr_accept) begin
                        if (wr_last) begin
                            rr_prio_reg <= ~grant_id_reg;
                            state_reg   <= ARB_IDLE;
                        end else begin
                            wr_beats_reg <= gm_burstcount - 1'b1;
                            burst_reg    <= gm_burstcount;
                            state_reg    <= ARB_WBURST;
                        end
                    end else if (fifo_push) begin
                        rr_prio_reg <= ~grant_id_reg;
                        state_reg   <= ARB_IDLE;
                    end
                end
                ARB_WBURST: begin
                    if (wr_accept) begin
                        if (wr_last) begin
                            rr_prio_reg <= ~grant_id_reg;
                            state_reg   <= ARB_IDLE;
                        end else begin
                            wr_beats_reg <= wr_beats_reg - 1'b1;
                        end
                    end
                end
                default: state_reg <= ARB_IDLE;
            endcase
        end
    end

    // ---------------- read return steering ----------------
    // rd_beats_reg == 0 means no burst in progress: the next beat starts the
    // head entry's burst. Beats arriving with nothing tracked are dropped.
    assign rdv_fire = s_readdatavalid && !fifo_empty;
    assign rd_cur   = (rd_beats_reg == '0) ? BURST_W'(fifo_head.beats) : rd_beats_reg;
    assign fifo_pop = rdv_fire && (rd_cur == BURST_W'(1));

    always_comb begin
        rd_beats_next = rd_beats_reg;
        if (rdv_fire) begin
            rd_beats_next = rd_cur - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_beats_reg <= '0;
        end else begin
            rd_beats_reg <= rd_beats_next;
        end
    end

    rd_track_fifo #(
        .DEPTH (RD_TRACK_DEPTH)
    ) u_rd_track (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    a_no_orphan_rdata : assert property (@(posedge clk) disable iff (reset)
        !(s_readdatavalid && fifo_empty));

`ifdef DDR_ARB_PERF_CNT_EN
    // ---------------- optional performance counters ----------------
    logic [31:0] perf_m0_cmds_reg;
    logic [31:0] perf_m1_cmds_reg;
    logic [31:0] perf_stall_reg;
    logic        cmd_done;
    logic        stall_any;

    assign cmd_done  = fifo_push || (wr_accept && wr_last);
    assign stall_any = ((m0_read || m0_write) && m_wait[0]) ||
                       ((m1_read || m1_write) && m_wait[1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_m0_cmds_reg <= '0;
            perf_m1_cmds_reg <= '0;
            perf_stall_reg   <= '0;
        end else begin
            if (cmd_done && !grant_id_reg) begin
                perf_m0_cmds_reg <= sat_inc32(perf_m0_cmds_reg);
            end
            if (cmd_done && grant_id_reg) begin
                perf_m1_cmds_reg <= sat_inc32(perf_m1_cmds_reg);
            end
            if (stall_any) begin
                perf_stall_reg <= sat_inc32(perf_stall_reg);
            end
        end
    end

    assign perf_m0_cmds      = perf_m0_cmds_reg;
    assign perf_m1_cmds      = perf_m1_cmds_reg;
    assign perf_stall_cycles = perf_stall_reg;
`endif

endmodule

// File: tb/tb_ddr_avmm_burst_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ddr_avmm_burst_arbiter
// Directed scenarios for the DDR4 burst arbiter. Tests push the expected slave
// commands and expected read-return beats into queues; two monitors pop and
// compare whenever the DUT presents an accepted command or a readdatavalid.
// ----------------------------------------------------------------------------
module tb_ddr_avmm_burst_arbiter;
    import ddr_arb_pkg::*;

    localparam int DW = 512;
    localparam int AW = 27;
    localparam int BW = 7;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] burst;
        logic [31:0]   data;
    } cmd_t;

    typedef struct {
        int          id;
        logic [31:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic            mr [2];
    logic            mw [2];
    logic [AW-1:0]   ma [2];
    logic [BW-1:0]   mb [2];
    logic [DW-1:0]   mwd [2];
    logic [DW/8-1:0] mbe [2];
    logic            mwait [2];
    logic            mrdv [2];
    logic [DW-1:0]   mrd [2];

    logic            s_read, s_write;
    logic [AW-1:0]   s_address;
    logic [BW-1:0]   s_burstcount;
    logic [DW-1:0]   s_writedata;
    logic [DW/8-1:0] s_byteenable;
    logic            s_waitrequest = 1'b0;
    logic [DW-1:0]   s_readdata = '0;
    logic            s_readdatavalid = 1'b0;
`ifdef DDR_ARB_PERF_CNT_EN
    logic [31:0]     perf_m0_cmds, perf_m1_cmds, perf_stall_cycles;
`endif

    int   checks = 0;
    int   failures = 0;
    cmd_t cmd_q [$];
    rd_t  rd_q [$];
    cmd_t mon_cmd;
    rd_t  mon_rd;
    bit   t3_wr_done, t3_rd_done;
    int   t3_viol;

    always #5 clk = ~clk;

    ddr_avmm_burst_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_read          (mr[0]),
        .m0_write         (mw[0]),
        .m0_address       (ma[0]),
        .m0_burstcount    (mb[0]),
        .m0_writedata     (mwd[0]),
        .m0_byteenable    (mbe[0]),
        .m0_waitrequest   (mwait[0]),
        .m0_readdata      (mrd[0]),
        .m0_readdatavalid (mrdv[0]),
        .m1_read          (mr[1]),
        .m1_write         (mw[1]),
        .m1_address       (ma[1]),
        .m1_burstcount    (mb[1]),
        .m1_writedata     (mwd[1]),
        .m1_byteenable    (mbe[1]),
        .m1_waitrequest   (mwait[1]),
        .m1_readdata      (mrd[1]),
        .m1_readdatavalid (mrdv[1]),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_address        (s_address),
        .s_burstcount     (s_burstcount),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid)
`ifdef DDR_ARB_PERF_CNT_EN
        ,
        .perf_m0_cmds      (perf_m0_cmds),
        .perf_m1_cmds      (perf_m1_cmds),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!reset && (s_read || s_write) && !s_waitrequest) begin
            if (cmd_q.size() == 0) begin
                check("cmd_unexpected", 64'(s_address), 64'hFFFF_FFFF);
            end else begin
                mon_cmd = cmd_q.pop_front();
                $display("txn cmd wr=%0d addr=0x%0h burst=%0d data=0x%0h",
                         s_write, s_address, s_burstcount, s_writedata[31:0]);
                check("cmd_wr", 64'(s_write), 64'(mon_cmd.wr));
                check("cmd_addr", 64'(s_address), 64'(mon_cmd.addr));
                check("cmd_burst", 64'(s_burstcount), 64'(mon_cmd.burst));
                if (mon_cmd.wr) check("cmd_wdata", 64'(s_writedata[31:0]), 64'(mon_cmd.data));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && (mrdv[0] || mrdv[1])) begin
            check("rdv_onehot", 64'(mrdv[0] && mrdv[1]), 64'd0);
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 64'(mrdv[1]), 64'hFFFF_FFFF);
            end else begin
                mon_rd = rd_q.pop_front();
                $display("txn rd m%0d data=0x%0h", mrdv[1] ? 1 : 0, s_readdata[31:0]);
                check("rd_id", mrdv[1] ? 64'd1 : 64'd0, 64'(mon_rd.id));
                check("rd_data", 64'(mrd[mon_rd.id][31:0]), 64'(mon_rd.data));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic do_read(input int id, input logic [AW-1:0] a, input logic [BW-1:0] b);
        bit ok = 1'b0;
        mr[id] = 1'b1; ma[id] = a; mb[id] = b;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            if (!mwait[id]) ok = 1'b1;
        end
        @(posedge clk); #1 mr[id] = 1'b0;
        check("read_accept", 64'(ok), 64'd1);
    endtask

    task automatic do_write(input int id, input logic [AW-1:0] a, input logic [BW-1:0] b,
                            input int nsend, input int base);
        for (int k = 0; k < nsend; k++) begin
            bit ok = 1'b0;
            mw[id] = 1'b1; ma[id] = a; mb[id] = b;
            mwd[id] = '0; mwd[id][31:0] = 32'(base + k);
            for (int c = 0; c < 400 && !ok; c++) begin
                @(negedge clk);
                if (!mwait[id]) ok = 1'b1;
            end
            @(posedge clk); #1;
            check("write_accept", 64'(ok), 64'd1);
        end
        mw[id] = 1'b0;
    endtask

    task automatic return_beats(input int id, input int n, input int base);
        for (int k = 0; k < n; k++) begin
            s_readdatavalid = 1'b1;
            s_readdata = '0; s_readdata[31:0] = 32'(base + k);
            rd_q.push_back('{id: id, data: 32'(base + k)});
            @(posedge clk); #1;
        end
        s_readdatavalid = 1'b0;
    endtask

    task automatic push_cmd(input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] b,
                            input int d);
        cmd_q.push_back('{wr: wr, addr: a, burst: b, data: 32'(d)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            mr[i] = 1'b0; mw[i] = 1'b0; ma[i] = '0; mb[i] = 7'd1;
            mwd[i] = '0; mbe[i] = '1;
        end

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_m0_wait", 64'(mwait[0]), 64'd1);
        check("rst_m1_wait", 64'(mwait[1]), 64'd1);
        check("rst_s_read",  64'(s_read), 64'd0);
        check("rst_s_write", 64'(s_write), 64'd0);
        check("rst_rdv",     64'(mrdv[0] | mrdv[1]), 64'd0);
        check("rst_state",   64'(dut.state_reg), 64'(ARB_IDLE));
        @(posedge clk); #1 reset = 1'b0;

        // T1: m0 read burst 4 at 0x10, four beats back to m0
        push_cmd(1'b0, 27'h10, 7'd4, 0);
        do_read(0, 27'h10, 7'd4);
        repeat (2) @(posedge clk); #1;
        return_beats(0, 4, 32'hA0);
        @(negedge clk);
        check("t1_fifo_empty", 64'(dut.u_rd_track.empty), 64'd1);
        @(posedge clk); #1;

        // T2: simultaneous reads from reset, m0 first then m1
        apply_reset();
        push_cmd(1'b0, 27'h100, 7'd2, 0);
        push_cmd(1'b0, 27'h200, 7'd3, 0);
        fork
            do_read(0, 27'h100, 7'd2);
            do_read(1, 27'h200, 7'd3);
        join
        return_beats(0, 2, 32'hB0);
        return_beats(1, 3, 32'hC0);
        @(posedge clk); #1;

        // T3: m1 4-beat write with toggling waitrequest, m0 read held off
        for (int k = 0; k < 4; k++) push_cmd(1'b1, 27'h300, 7'd4, 32'hF0 + k);
        push_cmd(1'b0, 27'h400, 7'd1, 0);
        t3_wr_done = 1'b0; t3_rd_done = 1'b0; t3_viol = 0;
        s_waitrequest = 1'b1;
        fork
            begin
                do_write(1, 27'h300, 7'd4, 4, 32'hF0);
                t3_wr_done = 1'b1;
            end
            begin
                @(posedge clk); #1;
                do_read(0, 27'h400, 7'd1);
                t3_rd_done = 1'b1;
            end
            begin
                for (int c = 0; c < 300 && !t3_rd_done; c++) begin
                    @(posedge clk); #1 s_waitrequest = ~s_waitrequest;
                end
                s_waitrequest = 1'b0;
            end
            begin
                for (int c = 0; c < 300 && !t3_wr_done; c++) begin
                    @(negedge clk);
                    if (!t3_wr_done && !mwait[0]) t3_viol++;
                end
            end
        join
        check("t3_m0_stalled", 64'(t3_viol), 64'd0);
        return_beats(0, 1, 32'h11);
        @(posedge clk); #1;

        // T4: 16 outstanding reads fill tracking; 17th holds until one returns
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            push_cmd(1'b0, 27'h700 + 27'(i), 7'd1, 0);
            do_read(0, 27'h700 + 27'(i), 7'd1);
        end
        push_cmd(1'b0, 27'h7FF, 7'd1, 0);
        fork
            do_read(0, 27'h7FF, 7'd1);
            begin
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    check("t4_hold_wait", 64'(mwait[0]), 64'd1);
                    check("t4_hold_sread", 64'(s_read), 64'd0);
                end
                @(posedge clk); #1;
                return_beats(0, 1, 32'hD0);
            end
        join

        // T5: reset during beat 2 of a 4-beat write
        apply_reset();
        push_cmd(1'b1, 27'h500, 7'd4, 32'hE0);
        push_cmd(1'b1, 27'h500, 7'd4, 32'hE1);
        do_write(0, 27'h500, 7'd4, 2, 32'hE0);
        mw[0] = 1'b1; mwd[0] = '0; mwd[0][31:0] = 32'hE2;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_state", 64'(dut.state_reg), 64'(ARB_IDLE));
        check("t5_s_write", 64'(s_write), 64'd0);
        check("t5_m0_wait", 64'(mwait[0]), 64'd1);
        check("t5_m1_wait", 64'(mwait[1]), 64'd1);
        check("t5_rr_prio", 64'(dut.rr_prio_reg), 64'd0);
        @(posedge clk); #1;
        mw[0] = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

`ifdef DDR_ARB_PERF_CNT_EN
        // Perf: 3 m0 reads, 2 m1 write bursts
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            push_cmd(1'b0, 27'h600 + 27'(i), 7'd1, 0);
            do_read(0, 27'h600 + 27'(i), 7'd1);
        end
        for (int i = 0; i < 2; i++) begin
            push_cmd(1'b1, 27'h680, 7'd2, 32'h50 + 2 * i);
            push_cmd(1'b1, 27'h680, 7'd2, 32'h51 + 2 * i);
            do_write(1, 27'h680, 7'd2, 2, 32'h50 + 2 * i);
        end
        @(negedge clk);
        check("perf_m0_cmds", 64'(perf_m0_cmds), 64'd3);
        check("perf_m1_cmds", 64'(perf_m1_cmds), 64'd2);
        @(posedge clk); #1;
`endif

        repeat (4) @(posedge clk);
        check("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
        check("rd_q_drained", 64'(rd_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr_avmm_burst_arbiter.md
Name: ddr_avmm_burst_arbiter

Overview:
- Shares one DDR4 Avalon-MM slave port between two Avalon-MM masters, N∈{0,1}: DMA master 0 and host/MMIO-to-DDR master 1.
- Sits between the DMA test system's DDR master and the DDR4 bank, in the DDR4 user-clock domain.
- Round-robin arbitration, burst-locked for writes.
- Tracks outstanding read bursts so that returned read data is steered to its originating master.

Parameters:
- DATA_W, 512, data width in bits.
- ADDR_W, 27, word address width (64-byte words).
- BURST_W, 7, burstcount width.
- RD_TRACK_DEPTH, 16, number of outstanding read commands tracked (power of 2, ≥2).

Ports:
- clk  input  1  DDR4 user clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high.
- mN_read  input  1  master N read request.
- mN_write  input  1  master N write beat.
- mN_address  input  ADDR_W  master N word address.
- mN_burstcount  input  BURST_W  master N burst length; 0 is illegal.
- mN_writedata  input  DATA_W  master N write data.
- mN_byteenable  input  DATA_W/8  master N byte enables.
- mN_waitrequest  output  1  stall to master N.
- mN_readdata  output  DATA_W  read data (broadcast to both masters).
- mN_readdatavalid  output  1  read beat belongs to master N.
- s_read, s_write  output  1  to DDR slave.
- s_address  output  ADDR_W  to DDR slave.
- s_burstcount  output  BURST_W  to DDR slave.
- s_writedata  output  DATA_W  to DDR slave.
- s_byteenable  output  DATA_W/8  to DDR slave.
- s_waitrequest  input  1  from DDR slave.
- s_readdata  input  DATA_W  from DDR slave.
- s_readdatavalid  input  1  from DDR slave.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - state=ARB_IDLE, grant_id=0, rr_prio=0 (master 0 preferred).
  - Tracking FIFO empty, write and read beat counters 0.
  - s_read=s_write=0, mN_waitrequest=1, mN_readdatavalid=0.
- ARB_IDLE:
  - No master forwarded; s_read=s_write=0; both mN_waitrequest=1.
  - A master requests when read|write is asserted.
  - If exactly one requests, it wins. If both request, rr_prio wins.
  - Register grant_id, go to ARB_CMD.
  - Arbitration latency: 1 cycle. One idle bubble between commands is accepted.
- ARB_CMD:
  - s_* are driven combinationally from the granted master.
  - Loser sees waitrequest=1. Winner's waitrequest = s_waitrequest.
  - Read is accepted when s_read & !s_waitrequest.
    - Push {grant_id, burstcount} into the FIFO.
    - rr_prio = ~grant_id; go to ARB_IDLE.
  - Read while FIFO full: s_read forced 0, winner waitrequest=1, state holds until a slot frees.
  - Push is blocked when the FIFO is full, even if a pop occurs in the same cycle.
  - Write beat accepted:
    - burstcount==1: rr_prio=~grant_id, go to ARB_IDLE.
    - Otherwise: wr_beats = burstcount-1, go to ARB_WBURST.
- ARB_WBURST:
  - Forwards only the granted master's writes; s_burstcount carries the first beat's latched value.
  - Each accepted beat decrements wr_beats. The beat accepted at wr_beats==1 ends the burst: rr_prio=~grant_id, go to ARB_IDLE.
  - The other master stays stalled for the whole burst.
  - Reads from the granted master during a burst are not forwarded (waitrequest=1 on the read).
- Read return:
  - On s_readdatavalid, assert mN_readdatavalid only for N = FIFO head id.
  - rd_beats is loaded from the head burstcount when idle, and decrements per beat.
  - Pop the head on its last beat.
  - s_readdatavalid with the FIFO empty is a protocol error: the beat is dropped, with a simulation assertion.
- Reset mid-operation:
  - All state clears in the same cycle.
  - Outstanding reads are forgotten; the DDR controller is reset by the same reset.

Optional Feature:
- Macro: DDR_ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_m0_cmds[31:0], perf_m1_cmds[31:0] and perf_stall_cycles[31:0].
  - perf_mN_cmds counts accepted read commands plus completed write bursts per master, saturating at 0xFFFFFFFF.
  - perf_stall_cycles counts cycles where any mN request is pending and that master's waitrequest=1, also saturating.
  - All counters clear on reset.
- Undefined: these ports are absent and no counter logic exists.

Decomposition:
- Package ddr_arb_pkg:
  - t_arb_state enum (ARB_IDLE, ARB_CMD, ARB_WBURST).
  - t_arb_id typedef (1 bit).
  - t_rd_track struct {t_arb_id id; logic [BURST_W-1:0] beats}.
  - Default width constants.
- Sub-module rd_track_fifo:
  - Synchronous FIFO of t_rd_track, depth RD_TRACK_DEPTH.
  - Ports: push, pop, full, empty, head.
  - Registered read, show-ahead.

Test Plan:
- m0 read burst=4 at addr 0x10, slave returns 4 beats → m0_readdatavalid pulses 4 times, m1_readdatavalid stays 0, FIFO empty afterwards.
- m0 and m1 both request reads from reset → m0 is granted first, then m1. Returned beats (m0 burst 2, m1 burst 3) are steered 2 to m0 then 3 to m1.
- m1 write burst=4 with s_waitrequest toggling every other cycle while m0 requests a read → m0 waitrequest=1 until the 4th m1 beat is accepted, then m0 is granted.
- Issue 16 read commands with no returns → the 17th holds with waitrequest=1. One completed burst frees a slot and the 17th is then accepted.
- Assert reset during beat 2 of a 4-beat write → next cycle state=ARB_IDLE, s_write=0, both waitrequest=1, rr_prio=0.
- With DDR_ARB_PERF_CNT_EN: 3 m0 reads and 2 m1 write bursts → perf_m0_cmds=3, perf_m1_cmds=2.
